// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - subtractive GCD engine: A/B datapath plus five-state controller
module gcd_controller #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic             lt;
    logic             gt;
    logic             eq;
    logic [WIDTH-1:0] sub_lhs;
    logic [WIDTH-1:0] sub_rhs;
    logic [WIDTH-1:0] diff;

    assign lt = (a_reg < b_reg);
    assign gt = (a_reg > b_reg);
    assign eq = (a_reg == b_reg);

    // Larger operand is always the minuend, so the difference never wraps.
    // With A==0 this yields B-0=B, which is exactly the A<=B load needed there.
    assign sub_lhs = gt ? a_reg : b_reg;
    assign sub_rhs = gt ? b_reg : a_reg;
    assign diff    = sub_lhs - sub_rhs;

    assign result = a_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    a_reg <= data_in;
                    state <= LOAD_B;
                end
                LOAD_B: begin
                    b_reg <= data_in;
                    state <= CALC;
                end
                CALC: begin
                    if (a_reg == '0) begin
                        a_reg <= diff;
                        state <= DONE;
                        done  <= 1'b1;
                    end else if ((b_reg == '0) || eq) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (gt) begin
                        a_reg <= diff;
                    end else if (lt) begin
                        b_reg <= diff;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_controller.sv
// tb/tb_gcd_controller.sv - directed self-checking bench for gcd_controller
module tb_gcd_controller;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             done;
    logic [WIDTH-1:0] result;

    int checks   = 0;
    int failures = 0;
    int a_trace[$];

    gcd_controller #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1 with the block in IDLE; returns just after the LOAD_B edge.
    task automatic load_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit drop_start, input string tag);
        start   = 1'b1;
        data_in = a;
        step();
        if (drop_start) start = 1'b0;
        step();
        check({tag, "_load_a"}, result, a);
        data_in = b;
        step();
        check({tag, "_calc_entry_done"}, done, 0);
        a_trace.delete();
    endtask

    task automatic wait_done(input int exp_edges, input logic [WIDTH-1:0] exp_result,
                             input int limit, input string tag);
        int edges = 0;
        while (!done && edges < limit) begin
            step();
            a_trace.push_back(int'(result));
            edges++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_edges"}, edges, exp_edges);
        check({tag, "_result"}, result, exp_result);
    endtask

    task automatic release_op(input string tag);
        start = 1'b0;
        step();
        check({tag, "_idle_done"}, done, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        #1;
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_reset_idle_done", done, 0);

        // Worked example with A trajectory and held-start behaviour
        load_op(16'd143, 16'd78, 1'b0, "ex143");
        wait_done(7, 16'd13, 20, "ex143");
        if (a_trace.size() == 7) begin
            check("ex143_trace1", a_trace[0], 65);
            check("ex143_trace2", a_trace[1], 65);
            check("ex143_trace3", a_trace[2], 52);
            check("ex143_trace4", a_trace[3], 39);
            check("ex143_trace5", a_trace[4], 26);
            check("ex143_trace6", a_trace[5], 13);
        end else begin
            check("ex143_trace_len", a_trace.size(), 7);
        end
        repeat (3) step();
        check("held_start_done", done, 1);
        check("held_start_result", result, 13);
        release_op("ex143");

        load_op(16'd25, 16'd25, 1'b0, "eq25");
        wait_done(1, 16'd25, 10, "eq25");
        release_op("eq25");

        load_op(16'd0, 16'd9, 1'b0, "zero_a");
        wait_done(1, 16'd9, 10, "zero_a");
        release_op("zero_a");

        load_op(16'd12, 16'd0, 1'b0, "zero_b");
        wait_done(1, 16'd12, 10, "zero_b");
        release_op("zero_b");

        load_op(16'd0, 16'd0, 1'b0, "zero_ab");
        wait_done(1, 16'd0, 10, "zero_ab");
        release_op("zero_ab");

        // start dropped right after the IDLE edge must not abort the operation
        load_op(16'd21, 16'd14, 1'b1, "drop21");
        wait_done(3, 16'd7, 10, "drop21");
        step();
        check("drop21_auto_idle", done, 0);

        // Reset in the middle of CALC
        load_op(16'd143, 16'd78, 1'b0, "rst_mid");
        repeat (3) step();
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("rst_mid_done", done, 0);
        check("rst_mid_result", result, 0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_mid_idle_done", done, 0);
        load_op(16'd48, 16'd18, 1'b0, "after_rst");
        wait_done(5, 16'd6, 20, "after_rst");
        release_op("after_rst");

        load_op(16'd21, 16'd14, 1'b0, "restart21");
        wait_done(3, 16'd7, 10, "restart21");
        release_op("restart21");

        // Coprime extreme: 65534 subtractions then the equality edge
        load_op(16'd65535, 16'd1, 1'b0, "coprime");
        wait_done(65535, 16'd1, 65600, "coprime");
        release_op("coprime");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result bit width.
REQ-002 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port: start, input, 1, level request; sampled in IDLE to begin an operation.
REQ-005 Port: data_in, input, WIDTH, operand bus; carries operand A, then operand B on the next cycle.
REQ-006 Port: done, output, 1, high while the result is valid.
REQ-007 Port: result, output, WIDTH, always equals the internal A register.

Function
REQ-008 The block SHALL contain a datapath and a controller in one module.
REQ-009 Datapath contents SHALL be:
  - registers A and B, each WIDTH bits;
  - per-register load muxes selecting data_in or the subtractor output;
  - one WIDTH-bit subtractor with operands selected by the controller;
  - a comparator producing lt, gt and eq for A versus B, unsigned.
REQ-010 The FSM SHALL have exactly five states: IDLE, LOAD_A, LOAD_B, CALC, DONE.
REQ-011 IDLE: if start=1 at a rising edge, go to LOAD_A; otherwise stay. No register changes.
REQ-012 LOAD_A: at the next edge, A <= data_in, then go to LOAD_B.
REQ-013 LOAD_B: at the next edge, B <= data_in, then go to CALC.
REQ-014 CALC SHALL perform one action per rising edge, chosen in priority order:
  - A==0: A <= B, go to DONE;
  - B==0: go to DONE with A unchanged;
  - A==B: go to DONE;
  - A>B: A <= A-B, stay in CALC;
  - A<B: B <= B-A, stay in CALC.
REQ-015 DONE: done=1 and A, B hold their values; stay while start=1; go to IDLE when start=0.
REQ-016 done SHALL be a Moore output, high only in DONE.
REQ-017 Subtraction SHALL never underflow, because only the larger operand is reduced.
REQ-018 Latency: done SHALL rise N+1 edges after the LOAD_B edge, where N is the number of subtractions performed.
REQ-019 gcd(x,0) = gcd(0,x) = x; gcd(0,0) = 0. These cases SHALL take exactly one CALC cycle.
REQ-020 start deasserted in LOAD_A, LOAD_B or CALC SHALL be ignored; the operation SHALL complete.
REQ-021 start held high continuously SHALL keep the block in DONE, with no automatic restart.

Reset
REQ-022 rst_n=0 SHALL immediately force: state IDLE, A=0, B=0, done=0, result=0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no residual effect on the next operation.
REQ-024 After rst_n rises, the first start sampled SHALL begin a fresh operation.

Verification
REQ-025 Worked example: start=1, then data_in=143 at the LOAD_A edge and 78 at the LOAD_B edge.
  - Required response: done rises at the 7th edge after the LOAD_B edge.
  - Required response: result = 13.
  - Required A sequence: 143, 65, 65, 52, 39, 26, 13.
REQ-026 Equal operands: A=B=25 -> done after 1 CALC edge, result=25.
REQ-027 Zero operands:
  - A=0, B=9 -> result=9;
  - A=12, B=0 -> result=12;
  - A=0, B=0 -> result=0;
  - each case with done after 1 CALC edge.
REQ-028 Coprime extremes: A=65535, B=1 -> result=1 after 65534 subtractions; done never asserts early.
REQ-029 Reset mid-CALC: assert rst_n=0 in CALC.
  - Required response: done=0 and result=0 immediately.
  - Then a new operation 48,18 -> result=6.
REQ-030 Handshake: drop start while in DONE.
  - Required response: IDLE next edge, done=0.
  - Then reassert start with 21,14 -> result=7.
